// File: rtl/kbd_serial_pkg.sv
// Shared encodings and defaults for the serial keyboard receiver.
// Holds RX/handshake FSM states and default timing/FIFO constants.
package kbd_serial_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 5208;
  localparam int unsigned FIFO_DEPTH_DEF   = 4;
  localparam int unsigned FIFO_AW_DEF      = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  typedef enum logic {
    H_IDLE,
    H_SERV
  } hs_state_e;

endpackage

// File: rtl/kbd_serial_if.sv
// IRQ/IACK/IEND handshake plus the acknowledged byte.
// master: peripheral (drives kbd/irq); slave: interrupt controller.
interface kbd_serial_if;

  logic [7:0] kbd;
  logic       irq;
  logic       iack;
  logic       iend;

  modport master (
    output kbd,
    output irq,
    input  iack,
    input  iend
  );

  modport slave (
    input  kbd,
    input  irq,
    output iack,
    output iend
  );

endinterface

// File: rtl/kbd_rx_fifo.sv
// Byte FIFO between the UART receiver and the IRQ handshake.
// Ports: push/din, pop/dout (head), full, empty, count.
module kbd_rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [FIFO_AW:0] count
);

  localparam int CNTW = FIFO_AW + 1;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               wr_en;
  logic               rd_en;

  assign full  = (count_q == CNTW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves this cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/kbd_serial_receiver.sv
// 8N1 keyboard receiver: sync, UART FSM, byte FIFO, IRQ handshake.
// Ports: CLK, RESET, RX, OVERRUN, FRAME_ERR; bus = kbd/irq/iack/iend.
module kbd_serial_receiver
  import kbd_serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int unsigned FIFO_AW      = FIFO_AW_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                RX,
  kbd_serial_if.master        bus,
  output logic                OVERRUN,
  output logic                FRAME_ERR
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_s1_q, rx_s2_q;
  rx_state_e       rx_st_q, rx_st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  hs_state_e       hs_q, hs_d;
  logic            irq_q, irq_d;
  logic [7:0]      kbd_q, kbd_d;

  logic            push;
  logic            pop;
  logic [7:0]      fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [FIFO_AW:0] fifo_count;

  kbd_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push),
    .pop   (pop),
    .din   (shift_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rx_st_d     = rx_st_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    unique case (rx_st_q)
      IDLE: begin
        if (!rx_s2_q) begin
          cnt_d   = '0;
          rx_st_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          bit_d = '0;
          // High at mid start bit: a glitch, not a frame.
          rx_st_d = rx_s2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_st_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (rx_s2_q) begin
            push    = 1'b1;
            rx_st_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_st_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BREAK: begin
        if (rx_s2_q) rx_st_d = IDLE;
      end
      default: rx_st_d = IDLE;
    endcase
  end

  always_comb begin
    hs_d  = hs_q;
    irq_d = irq_q;
    kbd_d = kbd_q;
    pop   = 1'b0;
    unique case (hs_q)
      H_IDLE: begin
        irq_d = (fifo_count != '0);
        if (bus.iack && irq_q) begin
          kbd_d = fifo_dout;
          irq_d = 1'b0;
          hs_d  = H_SERV;
        end
      end
      H_SERV: begin
        irq_d = 1'b0;
        if (bus.iend) begin
          pop  = !fifo_empty;
          hs_d = H_IDLE;
        end
      end
      default: hs_d = H_IDLE;
    endcase
  end

  // A byte is lost only if no slot frees up in the same cycle.
  assign overrun_d = overrun_q | (push & fifo_full & ~pop);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_st_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      hs_q        <= H_IDLE;
      irq_q       <= 1'b0;
      kbd_q       <= '0;
    end else begin
      rx_s1_q     <= RX;
      rx_s2_q     <= rx_s1_q;
      rx_st_q     <= rx_st_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      hs_q        <= hs_d;
      irq_q       <= irq_d;
      kbd_q       <= kbd_d;
    end
  end

  assign bus.kbd   = kbd_q;
  assign bus.irq   = irq_q;
  assign OVERRUN   = overrun_q;
  assign FRAME_ERR = frame_err_q;

endmodule
